// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Package    : fb_pkg
// Purpose    : Frame buffer geometry and loader state encoding. The display
//              address generator and the loader both use these definitions,
//              so the reader and writer agree on the image layout.
// Contents   : IMG_W, IMG_H, FB_PIXELS, FB_ADDR_W, FB_DATA_W, loader_state_t
// Revision   : 1.0 - initial release
// ============================================================================
package fb_pkg;

  // Image geometry. IMG_W must be a power of two so that the RAM address is
  // simply the row index concatenated above the column index.
  localparam int IMG_W     = 256;
  localparam int IMG_H     = 256;
  localparam int FB_PIXELS = IMG_W * IMG_H;
  localparam int FB_ADDR_W = $clog2(FB_PIXELS);
  localparam int FB_DATA_W = 8;

  // Loader FSM encoding, fixed at two bits.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CLEAR  = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_addr_counter.sv
`default_nettype none
// ============================================================================
// Module     : fb_addr_counter
// Purpose    : Pixel address counter for the frame buffer loader. Clears to
//              zero on request, increments once per issued write and flags
//              the final pixel of the frame.
// Ports      : clk      in  1       system clock
//              rst      in  1       synchronous reset, active-high
//              i_clr    in  1       force count to zero (takes priority)
//              i_en     in  1       advance count by one
//              o_count  out ADDR_W  current pixel index
//              o_last   out 1       current index is the last pixel
// Revision   : 1.0 - initial release
// ============================================================================
module fb_addr_counter #(
  parameter int ADDR_W = 16,
  parameter int LAST   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(LAST);

  logic [ADDR_W-1:0] r_count;

  // Natural binary wrap at the top: when the last pixel is written the
  // counter returns to zero, which is also where the next frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == c_LAST);

endmodule : fb_addr_counter
`default_nettype wire

// File: rtl/framebuffer_loader.sv
`default_nettype none
// ============================================================================
// Module     : framebuffer_loader
// Purpose    : Writer side of the grayscale image RAM. Takes a row-major pixel
//              byte stream (valid/ready) and writes it to the RAM write port,
//              or fills the whole frame with CLEAR_VALUE.
// Ports      : clk      in  1       system clock, rising edge
//              rst      in  1       synchronous reset, active-high
//              start    in  1       request: load one frame from the stream
//              clear    in  1       request: fill frame with CLEAR_VALUE
//              s_valid  in  1       stream byte valid
//              s_data   in  DATA_W  stream pixel byte
//              s_ready  out 1       byte accepted this cycle when s_valid
//              we       out 1       RAM write enable (registered)
//              waddr    out ADDR_W  RAM write address y*IMG_W + x
//              wdata    out DATA_W  RAM write data
//              busy     out 1       loading or clearing
//              done     out 1       one-cycle pulse with the last write
// Revision   : 1.0 - initial release
// ============================================================================
module framebuffer_loader #(
  parameter int                IMG_W       = fb_pkg::IMG_W,
  parameter int                IMG_H       = fb_pkg::IMG_H,
  parameter int                DATA_W      = fb_pkg::FB_DATA_W,
  parameter int                ADDR_W      = fb_pkg::FB_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  import fb_pkg::*;

  localparam int c_LAST_PIX = IMG_W * IMG_H - 1;

  loader_state_t     r_state;
  loader_state_t     w_state_nxt;

  logic              w_accept;
  logic              w_issue;
  logic              w_begin;
  logic [ADDR_W-1:0] w_count;
  logic              w_last;

  // ---------------------------------------------------------------------------
  // Handshake and write-issue decode
  // ---------------------------------------------------------------------------
  // s_ready depends on state only, so the source never sees a combinational
  // path from its own s_valid back to s_ready.
  assign s_ready  = (r_state == LOAD);
  assign w_accept = s_ready && s_valid;
  // A clear fill writes every cycle without any stream handshake.
  assign w_issue  = w_accept || (r_state == CLEAR);
  // Requests are only honoured from IDLE; the counter restarts on entry.
  assign w_begin  = (r_state == IDLE) && (start || clear);

  fb_addr_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (c_LAST_PIX)
  ) u_addr_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_begin),
    .i_en    (w_issue),
    .o_count (w_count),
    .o_last  (w_last)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        // clear has priority when both requests arrive together
        if (clear) begin
          w_state_nxt = CLEAR;
        end else if (start) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (w_accept && w_last) begin
          w_state_nxt = FINISH;
        end
      end
      CLEAR: begin
        if (w_last) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered RAM write port
  // ---------------------------------------------------------------------------
  // The write of the final pixel lands in the FINISH cycle, so we=1 with the
  // last address and done=1 coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      we      <= w_issue;
      if (w_issue) begin
        waddr <= w_count;
        wdata <= (r_state == LOAD) ? s_data : CLEAR_VALUE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, decoded from the state register
  // ---------------------------------------------------------------------------
  assign busy = (r_state == LOAD) || (r_state == CLEAR);
  assign done = (r_state == FINISH);

endmodule : framebuffer_loader
`default_nettype wire

// File: tb/tb_framebuffer_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_framebuffer_loader
// Purpose    : Self-checking bench. A full-size loader checks one complete
//              256x256 continuous load; a reduced 16x4 loader covers gapped
//              streams, clear fills, request priority, ignored requests and
//              reset mid-frame.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_framebuffer_loader;

  localparam int SM_W  = 16;
  localparam int SM_H  = 4;
  localparam int SM_AW = 6;
  localparam int SM_N  = SM_W * SM_H;
  localparam int BIG_N = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, clear, s_valid;
  logic [7:0]  s_data;
  logic        sel_big;

  logic        b_ready, b_we, b_busy, b_done;
  logic [15:0] b_waddr;
  logic [7:0]  b_wdata;
  logic        m_ready, m_we, m_busy, m_done;
  logic [SM_AW-1:0] m_waddr;
  logic [7:0]  m_wdata;

  logic        o_ready, o_we, o_busy, o_done;
  logic [15:0] o_waddr;
  logic [7:0]  o_wdata;

  framebuffer_loader u_big (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .s_valid(s_valid), .s_data(s_data), .s_ready(b_ready),
    .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .busy(b_busy), .done(b_done)
  );

  framebuffer_loader #(
    .IMG_W(SM_W), .IMG_H(SM_H), .DATA_W(8), .ADDR_W(SM_AW), .CLEAR_VALUE(8'h00)
  ) u_small (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .s_valid(s_valid), .s_data(s_data), .s_ready(m_ready),
    .we(m_we), .waddr(m_waddr), .wdata(m_wdata), .busy(m_busy), .done(m_done)
  );

  // Outputs of whichever instance is under test.
  always_comb begin
    o_ready = sel_big ? b_ready : m_ready;
    o_we    = sel_big ? b_we    : m_we;
    o_busy  = sel_big ? b_busy  : m_busy;
    o_done  = sel_big ? b_done  : m_done;
    o_wdata = sel_big ? b_wdata : m_wdata;
    o_waddr = sel_big ? b_waddr : {{(16-SM_AW){1'b0}}, m_waddr};
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: frame-level view of the loader. It tracks which kind of
  // frame is in progress, how many pixels have been issued, and the write that
  // must appear on the RAM port one cycle after it was issued.
  // --------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_LOAD, M_CLEAR, M_FIN} mmode_t;
  mmode_t mode;
  int     cnt, npix;
  bit     pend_v, pend_last;
  int     pend_a, pend_d;
  int     n_we, n_done;

  task automatic issue(input int d);
    pend_v    = 1'b1;
    pend_a    = cnt;
    pend_d    = d;
    pend_last = (cnt == npix - 1);
    cnt++;
    if (cnt == npix) mode = M_FIN;
  endtask

  task automatic advance(input logic v, input logic [7:0] d, input logic st, input logic cl);
    pend_v = 1'b0;
    case (mode)
      M_IDLE:  if (cl) begin mode = M_CLEAR; cnt = 0; end
               else if (st) begin mode = M_LOAD; cnt = 0; end
      M_LOAD:  if (v) issue(int'(d));
      M_CLEAR: issue(0);
      M_FIN:   mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    chk("we", 32'(o_we), 32'(pend_v));
    if (pend_v) begin
      chk("waddr", 32'(o_waddr), pend_a);
      chk("wdata", 32'(o_wdata), pend_d);
    end
    chk("done", 32'(o_done), 32'(pend_v && pend_last));
    chk("busy", 32'(o_busy), 32'(mode == M_LOAD || mode == M_CLEAR));
    chk("s_ready", 32'(o_ready), 32'(mode == M_LOAD));
    if (o_we === 1'b1) n_we++;
    if (o_done === 1'b1) n_done++;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic st, input logic cl);
    check_outputs();
    s_valid = v; s_data = d; start = st; clear = cl;
    advance(v, d, st, cl);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      rst = 1'b1; start = 1'b0; clear = 1'b0; s_valid = 1'b1; s_data = 8'($urandom);
      @(posedge clk); #1;
      chk("rst_we",    32'(o_we),    0);
      chk("rst_waddr", 32'(o_waddr), 0);
      chk("rst_wdata", 32'(o_wdata), 0);
      chk("rst_busy",  32'(o_busy),  0);
      chk("rst_done",  32'(o_done),  0);
      chk("rst_ready", 32'(o_ready), 0);
    end
    rst = 1'b0; mode = M_IDLE; pend_v = 1'b0; pend_last = 1'b0; cnt = 0;
  endtask

  // Runs the frame in progress to completion. Requests are raised while the
  // loader is busy (at pixel req_at) and during FINISH; all must be ignored.
  task automatic run_until_idle(input bit gap, input bit rnd, input int req_at);
    int   guard;
    logic v, st, cl;
    logic [7:0] d;
    guard = 0;
    while ((mode != M_IDLE || pend_v) && guard < 3 * npix + 20) begin
      v  = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      d  = rnd ? 8'($urandom) : 8'(cnt);
      st = (cnt == req_at) || (mode == M_FIN);
      cl = (cnt == req_at + 7) || (mode == M_FIN);
      step(v, d, st, cl);
      guard++;
    end
    chk("frame_timeout", 32'(mode != M_IDLE || pend_v), 0);
  endtask

  task automatic check_totals(input string name, input int w0, input int d0, input int exp_w);
    chk({name, "_writes"}, n_we - w0, exp_w);
    chk({name, "_done_pulses"}, n_done - d0, 1);
  endtask

  typedef struct {
    logic       st, cl, v;
    logic [7:0] d;
    logic       e_ready, e_we;
    logic [15:0] e_waddr;
    logic [7:0] e_wdata;
    logic       e_busy, e_done;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;

    // Gapped-stream opening, expectations derived by hand.
    //            st cl v  d      rdy we addr    data   busy done
    tbl[0] = '{1'b0,1'b0,1'b1,8'hAA, 1'b0,1'b0,16'd0,8'h00, 1'b0,1'b0}; // idle, byte offered
    tbl[1] = '{1'b1,1'b0,1'b1,8'hAB, 1'b0,1'b0,16'd0,8'h00, 1'b0,1'b0}; // start pulse
    tbl[2] = '{1'b0,1'b0,1'b1,8'h11, 1'b1,1'b0,16'd0,8'h00, 1'b1,1'b0}; // accept pixel 0
    tbl[3] = '{1'b0,1'b0,1'b0,8'h5A, 1'b1,1'b1,16'd0,8'h11, 1'b1,1'b0};
    tbl[4] = '{1'b0,1'b0,1'b0,8'h5B, 1'b1,1'b0,16'd0,8'h00, 1'b1,1'b0};
    tbl[5] = '{1'b0,1'b0,1'b1,8'h22, 1'b1,1'b0,16'd0,8'h00, 1'b1,1'b0}; // accept pixel 1
    tbl[6] = '{1'b1,1'b0,1'b1,8'h33, 1'b1,1'b1,16'd1,8'h22, 1'b1,1'b0}; // start ignored
    tbl[7] = '{1'b0,1'b1,1'b0,8'h44, 1'b1,1'b1,16'd2,8'h33, 1'b1,1'b0}; // clear ignored
    tbl[8] = '{1'b0,1'b0,1'b0,8'h55, 1'b1,1'b0,16'd0,8'h00, 1'b1,1'b0};

    rst = 1'b1; start = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    n_we = 0; n_done = 0; mode = M_IDLE; cnt = 0; pend_v = 1'b0; pend_last = 1'b0;

    // ---------------- full-size instance: continuous 65536-byte load -------
    sel_big = 1'b1; npix = BIG_N;
    do_reset(2);
    w0 = n_we; d0 = n_done;
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    run_until_idle(1'b0, 1'b0, 1000);
    repeat (3) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check_totals("big_load", w0, d0, BIG_N);

    // ---------------- reduced instance --------------------------------------
    sel_big = 1'b0; npix = SM_N;
    do_reset(2);

    // table-driven opening of a gapped load, then random gaps to the end
    w0 = n_we; d0 = n_done;
    for (int i = 0; i < 9; i++) begin
      chk("tbl_ready", 32'(o_ready), 32'(tbl[i].e_ready));
      chk("tbl_we",    32'(o_we),    32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk("tbl_waddr", 32'(o_waddr), 32'(tbl[i].e_waddr));
        chk("tbl_wdata", 32'(o_wdata), 32'(tbl[i].e_wdata));
      end
      chk("tbl_busy", 32'(o_busy), 32'(tbl[i].e_busy));
      chk("tbl_done", 32'(o_done), 32'(tbl[i].e_done));
      if (o_we === 1'b1) n_we++;
      if (o_done === 1'b1) n_done++;
      s_valid = tbl[i].v; s_data = tbl[i].d; start = tbl[i].st; clear = tbl[i].cl;
      advance(tbl[i].v, tbl[i].d, tbl[i].st, tbl[i].cl);
      @(posedge clk); #1;
    end
    run_until_idle(1'b1, 1'b1, -1);
    repeat (2) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check_totals("gap_load", w0, d0, SM_N);

    // clear fill, stream toggling underneath must not matter
    w0 = n_we; d0 = n_done;
    step(1'b1, 8'($urandom), 1'b0, 1'b1);
    run_until_idle(1'b1, 1'b1, 10);
    repeat (2) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    check_totals("clear", w0, d0, SM_N);

    // start and clear together: clear wins
    w0 = n_we; d0 = n_done;
    step(1'b1, 8'($urandom), 1'b1, 1'b1);
    run_until_idle(1'b1, 1'b1, 20);
    step(1'b0, 8'($urandom), 1'b0, 1'b0);
    check_totals("start_and_clear", w0, d0, SM_N);

    // load with requests mid-frame and in FINISH, all ignored
    w0 = n_we; d0 = n_done;
    step(1'b0, 8'($urandom), 1'b1, 1'b0);
    run_until_idle(1'b1, 1'b1, 20);
    repeat (2) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check_totals("ignored_req", w0, d0, SM_N);

    // reset in the middle of a load, then a fresh load from address 0
    d0 = n_done;
    step(1'b0, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 200 && cnt < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("pre_reset_progress", cnt, 30);
    do_reset(1);
    repeat (3) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("rst_no_done", n_done - d0, 0);
    w0 = n_we; d0 = n_done;
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    run_until_idle(1'b1, 1'b1, -1);
    step(1'b0, 8'($urandom), 1'b0, 1'b0);
    check_totals("after_reset", w0, d0, SM_N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_framebuffer_loader
`default_nettype wire
